morra_cinese_fsmd: RTL and testbench
====================================

MORRA_CINESE_FSMD -- requirements
Module: morra_cinese

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock for all state and outputs.
REQ-002 SHALL have ports: rst input 1, synchronous active-high reset.
REQ-003 SHALL have ports: P1 input 2, player-1 move, or configuration high bits when START=1.
REQ-004 SHALL have ports: P2 input 2, player-2 move, or configuration low bits when START=1.
REQ-005 SHALL have ports: START input 1, begin/configure a new game.
REQ-006 SHALL have ports: ROUND output 2, result of round evaluated at the last edge.
REQ-007 SHALL have ports: GAME output 2, game result, nonzero only on the game's final cycle.
REQ-008 SHALL use one clock and a synchronous, active-high reset (already decided).
REQ-009 SHALL use move encoding 00=no move/invalid, 01=rock, 10=paper, 11=scissors.
REQ-010 SHALL use ROUND encoding 00=invalid or none, 01=P1 wins, 10=P2 wins, 11=draw.
REQ-011 SHALL use GAME encoding 00=not finished, 01=P1 wins, 10=P2 wins, 11=draw.

Function
REQ-012 SHALL register ROUND and GAME, so each input sample's result appears after the next rising clk edge (1-cycle latency).
REQ-013 SHALL implement states IDLE and PLAY.
REQ-014 SHALL, when START=1 at an edge in any state: set MAX = 4 + {P1,P2} (range 4..19); clear round count, P1 wins and P2 wins; clear the last-winner/last-move memory; enter PLAY; drive ROUND=00 and GAME=00.
REQ-015 SHALL, in IDLE with START=0, ignore P1/P2 and drive ROUND=00 and GAME=00.
REQ-016 SHALL, in PLAY with START=0, treat a round as invalid if P1=00 or P2=00.
REQ-017 SHALL also treat a round as invalid if the previous valid round had a winner and that winner plays the same move it won with.
REQ-018 SHALL, for an invalid round, output ROUND=00 and leave all counters and the last-winner memory unchanged.
REQ-019 SHALL decide valid rounds as: rock beats scissors, scissors beats paper, paper beats rock; equal moves give a draw.
REQ-020 SHALL, for a valid round, increment the round count and the winner's win count, and store the winner and winning move.
REQ-021 SHALL, on a valid draw, clear the restriction so the next round has no repeat constraint.
REQ-022 SHALL end the game after a valid round when round count ≥ 4 and |P1 wins − P2 wins| ≥ 2; GAME is then the leader (01 or 10).
REQ-023 SHALL otherwise end the game after a valid round when round count = MAX; GAME is then the player with more wins, or 11 if wins are equal.
REQ-024 SHALL, at game end, present GAME together with the final round's ROUND in the same cycle, then return to IDLE; the next cycle outputs 00/00 unless START restarts.
REQ-025 SHALL size counters at 5 bits minimum; no wrap-around is reachable because MAX ≤ 19.
REQ-026 SHALL give START priority over move evaluation; START=1 mid-game aborts the game with GAME=00 and reconfigures it.

Reset
REQ-027 SHALL, on rst=1 at an edge: go to IDLE; set ROUND=00 and GAME=00; clear counters, MAX=4 and the memory; rst takes priority over START.
REQ-028 SHALL, when rst is asserted mid-game, discard the game; outputs stay 00/00 until a new START.

Verification
REQ-029 SHALL pass: rst, then START=0 with P1=01/P2=11 for 2 cycles -> ROUND=00 and GAME=00 throughout.
REQ-030 SHALL pass: START with config 00/00, then rounds 01v11, 11v10, 10v01, 01v11 -> ROUND=01 each round; GAME=00,00,00,01; next cycle 00/00.
REQ-031 SHALL pass, for the repeat rule: after a P1 win with 01v11, round 01v10 -> ROUND=00 and counts unchanged; then 10v10 -> 11; then 10v10 -> 11 (no restriction after draw).
REQ-032 SHALL pass: config 00/00 with four draws 01v01, 10v10, 11v11, 01v01 -> 4th cycle ROUND=11 and GAME=11.
REQ-033 SHALL pass, for the limit plus invalid moves: config P1=00/P2=01 (MAX=5), then 00v01 -> ROUND=00, not counted; then 5 rounds P1, P2, draw, draw, P1 -> GAME=01 on the 5th valid round.
REQ-034 SHALL pass, for restart: START 2 rounds into a game -> ROUND=00 and GAME=00; then a full new game completes correctly; rst mid-game behaves likewise.

Source files
------------

// File: rtl/morra_cinese_fsmd.sv
// Morra cinese (rock-paper-scissors) referee: configurable best-of game with a
// no-repeat rule for the previous winner, registered ROUND/GAME results.
module morra_cinese_fsmd (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] P1,
  input  logic [1:0] P2,
  input  logic       START,
  output logic [1:0] ROUND,
  output logic [1:0] GAME
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  // Winner of two non-zero moves; equal moves are a draw.
  function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    if (a == b) begin
      r = RES_DRAW;
    end else begin
      case ({a, b})
        4'b0111, 4'b1110, 4'b1001: r = RES_P1;
        default:                   r = RES_P2;
      endcase
    end
    return r;
  endfunction

  // Early finish on a two-win lead after four rounds, else finish at the limit.
  function automatic logic [1:0] game_result(input logic [4:0] rounds,
                                             input logic [4:0] max_rounds,
                                             input logic [4:0] p1w,
                                             input logic [4:0] p2w);
    logic [1:0] g;
    if ((rounds >= 5'd4) && (p1w >= (p2w + 5'd2))) begin
      g = RES_P1;
    end else if ((rounds >= 5'd4) && (p2w >= (p1w + 5'd2))) begin
      g = RES_P2;
    end else if (rounds == max_rounds) begin
      if (p1w > p2w) begin
        g = RES_P1;
      end else if (p2w > p1w) begin
        g = RES_P2;
      end else begin
        g = RES_DRAW;
      end
    end else begin
      g = RES_NONE;
    end
    return g;
  endfunction

  state_t     state_q, state_d;
  logic [4:0] max_q, max_d;
  logic [4:0] rounds_q, rounds_d;
  logic [4:0] p1w_q, p1w_d;
  logic [4:0] p2w_q, p2w_d;
  logic [1:0] last_win_q, last_win_d;
  logic [1:0] last_move_q, last_move_d;
  logic [1:0] round_q, round_d;
  logic [1:0] game_q, game_d;

  logic       repeat_s;
  logic       valid_s;
  logic [1:0] result_s;
  logic [4:0] rounds_n_s;
  logic [4:0] p1w_n_s;
  logic [4:0] p2w_n_s;
  logic [1:0] game_s;

  // Round evaluation: validity, winner and the would-be counters after it.
  always_comb begin
    repeat_s   = ((last_win_q == RES_P1) && (P1 == last_move_q)) ||
                 ((last_win_q == RES_P2) && (P2 == last_move_q));
    valid_s    = (state_q == PLAY) && (P1 != 2'b00) && (P2 != 2'b00) && !repeat_s;
    result_s   = judge(P1, P2);
    rounds_n_s = rounds_q + 5'd1;
    p1w_n_s    = (result_s == RES_P1) ? (p1w_q + 5'd1) : p1w_q;
    p2w_n_s    = (result_s == RES_P2) ? (p2w_q + 5'd1) : p2w_q;
    game_s     = game_result(rounds_n_s, max_q, p1w_n_s, p2w_n_s);
  end

  // Next-state and next-output logic; START overrides any evaluation.
  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    rounds_d    = rounds_q;
    p1w_d       = p1w_q;
    p2w_d       = p2w_q;
    last_win_d  = last_win_q;
    last_move_d = last_move_q;
    round_d     = RES_NONE;
    game_d      = RES_NONE;
    if (START) begin
      state_d     = PLAY;
      max_d       = 5'd4 + {1'b0, P1, P2};
      rounds_d    = 5'd0;
      p1w_d       = 5'd0;
      p2w_d       = 5'd0;
      last_win_d  = RES_NONE;
      last_move_d = 2'b00;
    end else if (valid_s) begin
      round_d  = result_s;
      rounds_d = rounds_n_s;
      p1w_d    = p1w_n_s;
      p2w_d    = p2w_n_s;
      case (result_s)
        RES_P1: begin
          last_win_d  = RES_P1;
          last_move_d = P1;
        end
        RES_P2: begin
          last_win_d  = RES_P2;
          last_move_d = P2;
        end
        default: begin
          last_win_d  = RES_NONE;
          last_move_d = 2'b00;
        end
      endcase
      game_d = game_s;
      if (game_s != RES_NONE) begin
        state_d = IDLE;
      end else begin
        state_d = PLAY;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      max_q       <= 5'd4;
      rounds_q    <= 5'd0;
      p1w_q       <= 5'd0;
      p2w_q       <= 5'd0;
      last_win_q  <= RES_NONE;
      last_move_q <= 2'b00;
      round_q     <= RES_NONE;
      game_q      <= RES_NONE;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      rounds_q    <= rounds_d;
      p1w_q       <= p1w_d;
      p2w_q       <= p2w_d;
      last_win_q  <= last_win_d;
      last_move_q <= last_move_d;
      round_q     <= round_d;
      game_q      <= game_d;
    end
  end

  assign ROUND = round_q;
  assign GAME  = game_q;

endmodule

// File: tb/tb_morra_cinese_fsmd.sv
// Scoreboard bench for morra_cinese_fsmd: the driver queues hand-computed
// ROUND/GAME per cycle, a monitor pops and compares one cycle later.
module tb_morra_cinese_fsmd;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] P1;
  logic [1:0] P2;
  logic       START;
  logic [1:0] ROUND;
  logic [1:0] GAME;

  logic [3:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         passes = 0;

  always #5 clk = ~clk;

  morra_cinese_fsmd dut (
    .clk  (clk),
    .rst  (rst),
    .P1   (P1),
    .P2   (P2),
    .START(START),
    .ROUND(ROUND),
    .GAME (GAME)
  );

  task automatic step(input logic [1:0] p1, input logic [1:0] p2, input logic st,
                      input logic r, input logic [1:0] er, input logic [1:0] eg,
                      input string nm);
    @(negedge clk);
    P1    = p1;
    P2    = p2;
    START = st;
    rst   = r;
    exp_q.push_back({er, eg});
    name_q.push_back(nm);
  endtask

  // Monitor: result of the inputs driven before each edge is visible just after it.
  initial begin
    logic [3:0] e;
    string      n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if ({ROUND, GAME} !== e) begin
          $display("FAIL %s: got ROUND=%b GAME=%b, expected ROUND=%b GAME=%b",
                   n, ROUND, GAME, e[3:2], e[1:0]);
        end else begin
          passes++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; START = 1'b0; P1 = 2'b00; P2 = 2'b00;
    step(2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, "reset");
    step(2'b01, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, "idle_a");
    step(2'b01, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, "idle_b");

    // Straight P1 wins, MAX=4
    step(2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, "cfg4");
    step(2'b01, 2'b11, 1'b0, 1'b0, 2'b01, 2'b00, "p1_r1");
    step(2'b11, 2'b10, 1'b0, 1'b0, 2'b01, 2'b00, "p1_r2");
    step(2'b10, 2'b01, 1'b0, 1'b0, 2'b01, 2'b00, "p1_r3");
    step(2'b01, 2'b11, 1'b0, 1'b0, 2'b01, 2'b01, "p1_r4_end");
    step(2'b01, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, "after_end");

    // Repeat rule and draw clearing the restriction
    step(2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, "cfg_rep");
    step(2'b01, 2'b11, 1'b0, 1'b0, 2'b01, 2'b00, "rep_win");
    step(2'b01, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, "rep_invalid");
    step(2'b10, 2'b10, 1'b0, 1'b0, 2'b11, 2'b00, "rep_draw1");
    step(2'b10, 2'b10, 1'b0, 1'b0, 2'b11, 2'b00, "rep_draw2");
    step(2'b11, 2'b10, 1'b0, 1'b0, 2'b01, 2'b01, "rep_end");

    // Four draws
    step(2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, "cfg_draw");
    step(2'b01, 2'b01, 1'b0, 1'b0, 2'b11, 2'b00, "draw_r1");
    step(2'b10, 2'b10, 1'b0, 1'b0, 2'b11, 2'b00, "draw_r2");
    step(2'b11, 2'b11, 1'b0, 1'b0, 2'b11, 2'b00, "draw_r3");
    step(2'b01, 2'b01, 1'b0, 1'b0, 2'b11, 2'b11, "draw_end");

    // MAX=5 with invalid moves
    step(2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, "cfg5");
    step(2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, "inv_p1_zero");
    step(2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "inv_p2_zero");
    step(2'b01, 2'b11, 1'b0, 1'b0, 2'b01, 2'b00, "m5_r1");
    step(2'b11, 2'b01, 1'b0, 1'b0, 2'b10, 2'b00, "m5_r2");
    step(2'b10, 2'b10, 1'b0, 1'b0, 2'b11, 2'b00, "m5_r3");
    step(2'b11, 2'b11, 1'b0, 1'b0, 2'b11, 2'b00, "m5_r4");
    step(2'b01, 2'b11, 1'b0, 1'b0, 2'b01, 2'b01, "m5_end");

    // MAX=19, P2 early lead of two
    step(2'b11, 2'b11, 1'b1, 1'b0, 2'b00, 2'b00, "cfg19");
    step(2'b11, 2'b01, 1'b0, 1'b0, 2'b10, 2'b00, "p2_r1");
    step(2'b01, 2'b11, 1'b0, 1'b0, 2'b01, 2'b00, "p2_r2");
    step(2'b10, 2'b11, 1'b0, 1'b0, 2'b10, 2'b00, "p2_r3");
    step(2'b11, 2'b01, 1'b0, 1'b0, 2'b10, 2'b10, "p2_early_end");

    // MAX=5, P2 ahead at the limit on a drawn final round
    step(2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, "cfg5b");
    step(2'b11, 2'b01, 1'b0, 1'b0, 2'b10, 2'b00, "lim_r1");
    step(2'b01, 2'b10, 1'b0, 1'b0, 2'b10, 2'b00, "lim_r2");
    step(2'b01, 2'b11, 1'b0, 1'b0, 2'b01, 2'b00, "lim_r3");
    step(2'b10, 2'b10, 1'b0, 1'b0, 2'b11, 2'b00, "lim_r4");
    step(2'b01, 2'b01, 1'b0, 1'b0, 2'b11, 2'b10, "lim_end");

    // START abort mid-game, then full game
    step(2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, "cfg_ab");
    step(2'b01, 2'b11, 1'b0, 1'b0, 2'b01, 2'b00, "ab_r1");
    step(2'b11, 2'b10, 1'b0, 1'b0, 2'b01, 2'b00, "ab_r2");
    step(2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, "abort_start");
    step(2'b01, 2'b11, 1'b0, 1'b0, 2'b01, 2'b00, "new_r1");
    step(2'b11, 2'b10, 1'b0, 1'b0, 2'b01, 2'b00, "new_r2");
    step(2'b10, 2'b01, 1'b0, 1'b0, 2'b01, 2'b00, "new_r3");
    step(2'b01, 2'b11, 1'b0, 1'b0, 2'b01, 2'b01, "new_end");

    // rst mid-game beats START, then idle until a fresh START
    step(2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, "cfg_rst");
    step(2'b01, 2'b11, 1'b0, 1'b0, 2'b01, 2'b00, "rst_r1");
    step(2'b00, 2'b11, 1'b1, 1'b1, 2'b00, 2'b00, "rst_over_start");
    step(2'b11, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, "rst_idle");
    step(2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, "cfg_after_rst");
    step(2'b01, 2'b01, 1'b0, 1'b0, 2'b11, 2'b00, "ar_r1");
    step(2'b10, 2'b10, 1'b0, 1'b0, 2'b11, 2'b00, "ar_r2");
    step(2'b11, 2'b11, 1'b0, 1'b0, 2'b11, 2'b00, "ar_r3");
    step(2'b01, 2'b01, 1'b0, 1'b0, 2'b11, 2'b11, "ar_end");
    step(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, "final_idle");

    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() > 0) @(posedge clk);
    end
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expected results left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
